// File: rtl/rv_iopmp_pkg.sv
// rv_iopmp_pkg
//   Shared types and constants for the IOPMP datapath blocks.
//   access_t   : transaction access type carried with a request
//   ERR_*      : error codes reported on rsp_err_type_o
package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_EXEC  = 2'd3
    } access_t;

    localparam logic [2:0] ERR_READ   = 3'h1;
    localparam logic [2:0] ERR_WRITE  = 3'h2;
    localparam logic [2:0] ERR_NO_HIT = 3'h5;

endpackage

// File: rtl/rv_iopmp_dl_prio_enc.sv
// rv_iopmp_dl_prio_enc
//   Masked lowest-index priority encoder.
//   req_i  : per-slot request (entry match)
//   mask_i : per-slot enable; a slot only competes when its mask bit is set
//   hit_o  : at least one enabled slot is requesting
//   idx_o  : index of the lowest enabled requesting slot (0 when no hit)
module rv_iopmp_dl_prio_enc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && req_i[i] && mask_i[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

    assign hit_o = found;
    assign idx_o = idx;

endmodule

// File: rtl/rv_iopmp_dl_sequencer.sv
// rv_iopmp_dl_sequencer
//   Walks the IOPMP entry range of a requester's source ID in windows of
//   NUMBER_INSTANCES entries, picking the lowest-index matching entry and
//   producing a single permit/error response per request.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   enable_i                     : IOPMP enable, captured at request accept
//   req_valid_i/req_ready_o      : request handshake (ready only when idle)
//   req_sid_i, req_access_i      : requester SID and access type
//   entry_lo_i/entry_hi_i        : entry range [lo, hi) for the SID
//   entry_offset_o               : first entry of the window under test
//   entry_match_i/entry_allow_i  : per-slot match/permit for that window
//   rsp_valid_o/rsp_ready_i      : response handshake
//   rsp_sid_o, rsp_allow_o, rsp_err_o, rsp_err_type_o, rsp_err_index_o
//                                : response payload
//   busy_o                       : a request is in flight
module rv_iopmp_dl_sequencer
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned SID_WIDTH        = 8,
    parameter int unsigned NUMBER_ENTRIES   = 32,
    parameter int unsigned NUMBER_INSTANCES = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        enable_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [SID_WIDTH-1:0]        req_sid_i,
    input  access_t                     req_access_i,
    input  logic [8:0]                  entry_lo_i,
    input  logic [8:0]                  entry_hi_i,
    output logic [8:0]                  entry_offset_o,
    input  logic [NUMBER_INSTANCES-1:0] entry_match_i,
    input  logic [NUMBER_INSTANCES-1:0] entry_allow_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [SID_WIDTH-1:0]        rsp_sid_o,
    output logic                        rsp_allow_o,
    output logic                        rsp_err_o,
    output logic [2:0]                  rsp_err_type_o,
    output logic [15:0]                 rsp_err_index_o,
    output logic                        busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int unsigned SLOT_W = (NUMBER_INSTANCES > 1) ? $clog2(NUMBER_INSTANCES) : 1;

    logic [1:0]           state_q, state_d;
    logic [8:0]           offset_q, offset_d;
    logic [8:0]           hi_q, hi_d;
    logic                 en_q, en_d;
    access_t              access_q, access_d;
    logic [SID_WIDTH-1:0] sid_q, sid_d;
    logic [SID_WIDTH-1:0] rsp_sid_q, rsp_sid_d;
    logic                 rsp_allow_q, rsp_allow_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [2:0]           rsp_err_type_q, rsp_err_type_d;
    logic [15:0]          rsp_err_index_q, rsp_err_index_d;

    logic [NUMBER_INSTANCES-1:0] slot_valid;
    logic                        hit;
    logic [SLOT_W-1:0]           hit_slot;
    logic [9:0]                  offset_ext;
    logic [9:0]                  next_offset;
    logic [9:0]                  hit_entry;
    logic                        last_window;

    // Offset arithmetic is carried in 10 bits so entries near 511 never wrap.
    assign offset_ext  = {1'b0, offset_q};
    assign next_offset = offset_ext + 10'(NUMBER_INSTANCES);
    assign hit_entry   = offset_ext + 10'(hit_slot);
    assign last_window = (next_offset >= {1'b0, hi_q}) ||
                         (next_offset >= 10'(NUMBER_ENTRIES));

    // Slots at or past hi (or past the implemented entry count) never compete.
    always_comb begin
        logic [9:0] slot_entry;
        slot_valid = '0;
        for (int unsigned i = 0; i < NUMBER_INSTANCES; i++) begin
            slot_entry    = offset_ext + 10'(i);
            slot_valid[i] = (slot_entry < {1'b0, hi_q}) &&
                            (slot_entry < 10'(NUMBER_ENTRIES));
        end
    end

    rv_iopmp_dl_prio_enc #(
        .WIDTH (NUMBER_INSTANCES),
        .IDX_W (SLOT_W)
    ) u_prio_enc (
        .req_i  (entry_match_i),
        .mask_i (slot_valid),
        .hit_o  (hit),
        .idx_o  (hit_slot)
    );

    always_comb begin
        state_d         = state_q;
        offset_d        = offset_q;
        hi_d            = hi_q;
        en_d            = en_q;
        access_d        = access_q;
        sid_d           = sid_q;
        rsp_sid_d       = rsp_sid_q;
        rsp_allow_d     = rsp_allow_q;
        rsp_err_d       = rsp_err_q;
        rsp_err_type_d  = rsp_err_type_q;
        rsp_err_index_d = rsp_err_index_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    sid_d    = req_sid_i;
                    access_d = req_access_i;
                    hi_d     = entry_hi_i;
                    en_d     = enable_i;
                    offset_d = entry_lo_i;
                    state_d  = ST_SCAN;
                end
            end
            // Every request spends at least one cycle here so the response
            // latency is one cycle per window, including the disabled case.
            // An empty range (lo >= hi) masks every slot and falls through to
            // the no-hit branch on its first window.
            ST_SCAN: begin
                rsp_sid_d = sid_q;
                if (!en_q) begin
                    rsp_allow_d     = 1'b1;
                    rsp_err_d       = 1'b0;
                    rsp_err_type_d  = '0;
                    rsp_err_index_d = '0;
                    state_d         = ST_RESP;
                end else if (hit) begin
                    if (entry_allow_i[hit_slot]) begin
                        rsp_allow_d     = 1'b1;
                        rsp_err_d       = 1'b0;
                        rsp_err_type_d  = '0;
                        rsp_err_index_d = '0;
                    end else begin
                        rsp_allow_d     = 1'b0;
                        rsp_err_d       = 1'b1;
                        rsp_err_type_d  = (access_q == ACCESS_READ) ? ERR_READ : ERR_WRITE;
                        rsp_err_index_d = 16'(hit_entry);
                    end
                    state_d = ST_RESP;
                end else if (last_window) begin
                    rsp_allow_d     = 1'b0;
                    rsp_err_d       = 1'b1;
                    rsp_err_type_d  = ERR_NO_HIT;
                    rsp_err_index_d = '0;
                    state_d         = ST_RESP;
                end else begin
                    offset_d = next_offset[8:0];
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            offset_q        <= '0;
            hi_q            <= '0;
            en_q            <= 1'b0;
            access_q        <= ACCESS_NONE;
            sid_q           <= '0;
            rsp_sid_q       <= '0;
            rsp_allow_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_err_type_q  <= '0;
            rsp_err_index_q <= '0;
        end else begin
            state_q         <= state_d;
            offset_q        <= offset_d;
            hi_q            <= hi_d;
            en_q            <= en_d;
            access_q        <= access_d;
            sid_q           <= sid_d;
            rsp_sid_q       <= rsp_sid_d;
            rsp_allow_q     <= rsp_allow_d;
            rsp_err_q       <= rsp_err_d;
            rsp_err_type_q  <= rsp_err_type_d;
            rsp_err_index_q <= rsp_err_index_d;
        end
    end

    assign req_ready_o     = (state_q == ST_IDLE);
    assign busy_o          = (state_q != ST_IDLE);
    assign rsp_valid_o     = (state_q == ST_RESP);
    assign entry_offset_o  = offset_q;
    assign rsp_sid_o       = rsp_sid_q;
    assign rsp_allow_o     = rsp_allow_q;
    assign rsp_err_o       = rsp_err_q;
    assign rsp_err_type_o  = rsp_err_type_q;
    assign rsp_err_index_o = rsp_err_index_q;

endmodule

// File: tb/tb_rv_iopmp_dl_sequencer.sv
// tb_rv_iopmp_dl_sequencer
//   Directed bench: a small entry table drives match/allow combinationally
//   from entry_offset_o; each scenario has hand-computed expected results.
module tb_rv_iopmp_dl_sequencer;
    import rv_iopmp_pkg::*;

    localparam int unsigned NI = 8;

    logic        clk_i;
    logic        rst_i;
    logic        enable_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [7:0]  req_sid_i;
    access_t     req_access_i;
    logic [8:0]  entry_lo_i;
    logic [8:0]  entry_hi_i;
    logic [8:0]  entry_offset_o;
    logic [NI-1:0] entry_match_i;
    logic [NI-1:0] entry_allow_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [7:0]  rsp_sid_o;
    logic        rsp_allow_o;
    logic        rsp_err_o;
    logic [2:0]  rsp_err_type_o;
    logic [15:0] rsp_err_index_o;
    logic        busy_o;

    logic match_mem [512];
    logic allow_mem [512];

    int n_checks;
    int n_fail;

    int       k;
    logic [8:0] offs [16];
    int       n_off;

    rv_iopmp_dl_sequencer #(
        .SID_WIDTH        (8),
        .NUMBER_ENTRIES   (32),
        .NUMBER_INSTANCES (NI)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .enable_i        (enable_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_sid_i       (req_sid_i),
        .req_access_i    (req_access_i),
        .entry_lo_i      (entry_lo_i),
        .entry_hi_i      (entry_hi_i),
        .entry_offset_o  (entry_offset_o),
        .entry_match_i   (entry_match_i),
        .entry_allow_i   (entry_allow_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_sid_o       (rsp_sid_o),
        .rsp_allow_o     (rsp_allow_o),
        .rsp_err_o       (rsp_err_o),
        .rsp_err_type_o  (rsp_err_type_o),
        .rsp_err_index_o (rsp_err_index_o),
        .busy_o          (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always_comb begin
        entry_match_i = '0;
        entry_allow_i = '0;
        for (int i = 0; i < NI; i++) begin
            if (int'(entry_offset_o) + i < 512) begin
                entry_match_i[i] = match_mem[int'(entry_offset_o) + i];
                entry_allow_i[i] = allow_mem[int'(entry_offset_o) + i];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) begin
            match_mem[i] = 1'b0;
            allow_mem[i] = 1'b0;
        end
    endtask

    // Issues one request from a post-edge point, then scrambles lo/hi/enable
    // and counts cycles until rsp_valid_o, recording the window offsets.
    task automatic run_req(input logic [7:0] sid, input access_t acc,
                           input logic [8:0] lo, input logic [8:0] hi,
                           input logic en);
        req_sid_i    = sid;
        req_access_i = acc;
        entry_lo_i   = lo;
        entry_hi_i   = hi;
        enable_i     = en;
        req_valid_i  = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i  = 1'b0;
        entry_lo_i   = 9'h1FF;
        entry_hi_i   = 9'h000;
        enable_i     = ~en;
        k     = 0;
        n_off = 0;
        while (!rsp_valid_o && k < 64) begin
            if (n_off < 16) begin
                offs[n_off] = entry_offset_o;
                n_off++;
            end
            @(posedge clk_i); #1;
            k++;
        end
        check_eq("rsp_valid_within_budget", rsp_valid_o, 1'b1);
    endtask

    task automatic finish_rsp();
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        check_eq("idle_after_handshake", {rsp_valid_o, busy_o, req_ready_o}, 3'b001);
    endtask

    task automatic check_rsp(input string tag, input int exp_k, input logic [7:0] sid,
                             input logic allow, input logic err,
                             input logic [2:0] typ, input logic [15:0] idx);
        check_eq({tag, "_latency"}, k, exp_k);
        check_eq({tag, "_sid"}, rsp_sid_o, sid);
        check_eq({tag, "_allow_err"}, {rsp_allow_o, rsp_err_o}, {allow, err});
        check_eq({tag, "_err_type"}, rsp_err_type_o, typ);
        check_eq({tag, "_err_index"}, rsp_err_index_o, idx);
    endtask

    initial begin
        int seen_valid;
        n_checks     = 0;
        n_fail       = 0;
        rst_i        = 1'b1;
        enable_i     = 1'b1;
        req_valid_i  = 1'b0;
        req_sid_i    = '0;
        req_access_i = ACCESS_READ;
        entry_lo_i   = '0;
        entry_hi_i   = '0;
        rsp_ready_i  = 1'b0;
        clear_mem();

        // Reset state
        #12;
        check_eq("rst_ready_busy_valid", {req_ready_o, busy_o, rsp_valid_o}, 3'b100);
        check_eq("rst_offset", entry_offset_o, 9'd0);
        check_eq("rst_payload", {rsp_sid_o, rsp_allow_o, rsp_err_o, rsp_err_type_o, rsp_err_index_o}, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Match at entry 19 of [0,32): windows 0, 8, 16, allowed
        match_mem[19] = 1'b1;
        allow_mem[19] = 1'b1;
        run_req(8'h3C, ACCESS_READ, 9'd0, 9'd32, 1'b1);
        check_eq("walk_offsets", {offs[0], offs[1], offs[2]}, {9'd0, 9'd8, 9'd16});
        check_rsp("walk", 3, 8'h3C, 1'b1, 1'b0, 3'h0, 16'd0);
        finish_rsp();

        // Entries 6 and 9 match in [4,12); entry 6 denies a read
        clear_mem();
        match_mem[6] = 1'b1;
        match_mem[9] = 1'b1;
        allow_mem[9] = 1'b1;
        run_req(8'h41, ACCESS_READ, 9'd4, 9'd12, 1'b1);
        check_rsp("prio_read", 1, 8'h41, 1'b0, 1'b1, ERR_READ, 16'd6);
        // Hold the response 4 cycles while another request is offered
        req_sid_i   = 8'h77;
        req_valid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i); #1;
            check_eq("hold_stable", {rsp_valid_o, req_ready_o, rsp_sid_o, rsp_err_type_o, rsp_err_index_o[7:0]},
                     {1'b1, 1'b0, 8'h41, ERR_READ, 8'd6});
        end
        req_valid_i = 1'b0;
        finish_rsp();

        // Same table, write access -> write error
        run_req(8'h42, ACCESS_WRITE, 9'd4, 9'd12, 1'b1);
        check_rsp("prio_write", 1, 8'h42, 1'b0, 1'b1, ERR_WRITE, 16'd6);
        finish_rsp();

        // Only entry 14 matches but hi=13 masks it
        clear_mem();
        match_mem[14] = 1'b1;
        allow_mem[14] = 1'b1;
        run_req(8'h05, ACCESS_READ, 9'd8, 9'd13, 1'b1);
        check_rsp("masked", 1, 8'h05, 1'b0, 1'b1, ERR_NO_HIT, 16'd0);
        finish_rsp();

        // Disabled at accept: a denying match is ignored
        clear_mem();
        match_mem[6] = 1'b1;
        run_req(8'h11, ACCESS_WRITE, 9'd4, 9'd12, 1'b0);
        check_rsp("disabled", 1, 8'h11, 1'b1, 1'b0, 3'h0, 16'd0);
        finish_rsp();

        // Empty range lo == hi
        match_mem[5] = 1'b1;
        run_req(8'h12, ACCESS_READ, 9'd5, 9'd5, 1'b1);
        check_rsp("empty", 1, 8'h12, 1'b0, 1'b1, ERR_NO_HIT, 16'd0);
        finish_rsp();

        // Last valid entry (hi-1 = 19) denies a write, third window
        clear_mem();
        match_mem[19] = 1'b1;
        run_req(8'h20, ACCESS_WRITE, 9'd0, 9'd20, 1'b1);
        check_rsp("last_slot", 3, 8'h20, 1'b0, 1'b1, ERR_WRITE, 16'd19);
        finish_rsp();

        // Match exactly at hi is masked -> no hit after three windows
        clear_mem();
        match_mem[20] = 1'b1;
        allow_mem[20] = 1'b1;
        run_req(8'h21, ACCESS_READ, 9'd0, 9'd20, 1'b1);
        check_rsp("at_hi", 3, 8'h21, 1'b0, 1'b1, ERR_NO_HIT, 16'd0);
        finish_rsp();

        // Reset asserted mid-SCAN abandons the request
        clear_mem();
        req_sid_i    = 8'h99;
        req_access_i = ACCESS_READ;
        entry_lo_i   = 9'd0;
        entry_hi_i   = 9'd32;
        enable_i     = 1'b1;
        req_valid_i  = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check_eq("mid_scan_busy", {busy_o, entry_offset_o}, {1'b1, 9'd8});
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("async_rst_ctrl", {req_ready_o, busy_o, rsp_valid_o, entry_offset_o}, {3'b100, 9'd0});
        check_eq("async_rst_payload", {rsp_sid_o, rsp_allow_o, rsp_err_o, rsp_err_type_o, rsp_err_index_o}, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        seen_valid = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o || busy_o) seen_valid++;
        end
        check_eq("no_rsp_after_rst", seen_valid, 0);

        // Fresh request after reset
        match_mem[3] = 1'b1;
        allow_mem[3] = 1'b1;
        run_req(8'hA5, ACCESS_WRITE, 9'd0, 9'd8, 1'b1);
        check_rsp("post_rst", 1, 8'hA5, 1'b1, 1'b0, 3'h0, 16'd0);
        finish_rsp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
